fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC register and issues in-order requests to a variable-latency instruction memory.
- Buffers returned instructions in a small show-ahead FIFO with their PCs, and presents instruction/PCF/PCPlus4F to IF/ID.
- Handles hazard-unit stalls and execute-stage redirects, discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

    // Instruction value presented to IF/ID when nothing is buffered.
    localparam logic [31:0] NOP_INSTR = 32'h00000000;

    // One buffered fetch: the address it came from and the returned word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Pointer width for a FIFO of the given depth (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic show-ahead synchronous FIFO with flush. The head word is visible on
// dout without a read strobe; pop consumes it at the clock edge. A push in the
// same cycle as flush is dropped. Pop on empty is ignored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !flush;
    assign pop_ok  = pop && !flush && !empty;
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping; flush empties in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to a
// variable-latency instruction memory, buffers responses in a show-ahead FIFO
// and presents the head to IF/ID. Redirects flush the buffer and discard any
// responses still in flight.
// Optional build macro FETCH_PERF_EN adds saturating pop/discard counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        fetch_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int EW = $bits(fetch_entry_t);

    logic [31:0]   pc;
    logic [PW:0]   drop_cnt;
    logic [PW:0]   outstanding;   // occupancy of the PC queue
    logic [PW:0]   fifo_count;
    logic          fifo_empty;
    logic          pcq_empty;
    logic [31:0]   pcq_head;
    logic [EW-1:0] fifo_dout;
    fetch_entry_t  head;
    fetch_entry_t  rsp_entry;
    logic          credit_ok;
    logic          accept;
    logic          discard;
    logic          push_instr;
    logic          pop;
    logic          rsp_acct;

    // Every outstanding request already owns a FIFO slot, so the FIFO can
    // never overflow however late the responses arrive.
    assign credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < (PW+2)'(DEPTH);
    assign imem_req   = !rst && credit_ok && !PCSrcE;
    assign imem_addr  = pc;
    assign accept     = imem_req && imem_ready;

    // A response is stale if it predates a redirect (pending drops) or lands
    // in the redirect cycle itself.
    assign rsp_acct   = imem_rvalid && !pcq_empty;
    assign discard    = imem_rvalid && (PCSrcE || drop_cnt != '0);
    assign push_instr = rsp_acct && !discard;
    assign pop        = fetch_valid && !StallF && !PCSrcE;

    assign rsp_entry.pc    = pcq_head;
    assign rsp_entry.instr = imem_rdata;
    assign head            = fetch_entry_t'(fifo_dout);

    assign fetch_valid = !fifo_empty;
    assign instruction = fetch_valid ? head.instr : NOP_INSTR;
    assign PCF         = fetch_valid ? head.pc : 32'h0;
    assign PCPlus4F    = fetch_valid ? head.pc + 32'd4 : 32'h0;

    // Addresses of issued requests, paired with responses in order.
    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (accept),
        .din   (pc),
        .pop   (imem_rvalid),
        .dout  (pcq_head),
        .empty (pcq_empty),
        .count (outstanding)
    );

    // Returned instructions with their PCs, awaiting IF/ID.
    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (PCSrcE),
        .push  (push_instr),
        .din   (rsp_entry),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // PC update: redirect wins, otherwise advance on an accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else if (PCSrcE)
            pc <= PCTargetE;
        else if (accept)
            pc <= pc + 32'd4;
    end

    // Stale-response counter: on redirect, everything still outstanding after
    // this cycle's response must be thrown away (no accept in that cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if (PCSrcE)
            drop_cnt <= outstanding - (PW+1)'(rsp_acct);
        else if (imem_rvalid && drop_cnt != '0)
            drop_cnt <= drop_cnt - (PW+1)'(1);
    end

`ifdef FETCH_PERF_EN
    // Saturating counts of instructions handed to IF/ID and responses dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (discard && perf_dropped != '1)
                perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a fixed-latency in-order memory model
// and a scoreboard of accepted addresses, popped as IF/ID consumes entries.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        fetch_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    fetch_unit #(.DEPTH(2), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .fetch_valid (fetch_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] model_pc;
    logic [31:0] mem_addr_q [$];
    int          mem_due_q  [$];
    logic [31:0] exp_q      [$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h0013_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic tick();
        logic [31:0] e;
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        if (PCSrcE) begin
            chk("redirect_no_req", imem_req, 1'b0);
            exp_q.delete();
            model_pc = PCTargetE;
        end else if (fetch_valid && !StallF) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", fetch_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("pcf", PCF, e);
                chk("instr", instruction, mem_data(e));
                chk("pcplus4", PCPlus4F, e + 32'd4);
            end
        end
        if (imem_req && imem_ready) begin
            chk("issue_addr", imem_addr, model_pc);
            mem_addr_q.push_back(imem_addr);
            mem_due_q.push_back(cyc + lat);
            exp_q.push_back(imem_addr);
            model_pc = model_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_valid"}, fetch_valid, 1'b0);
        chk({tag, "_instr"}, instruction, 32'h0);
        chk({tag, "_pcf"}, PCF, 32'h0);
        chk({tag, "_pcp4"}, PCPlus4F, 32'h0);
    endtask

    initial begin
        logic [31:0] addr0;
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        model_pc = RESET_PC;
        #3;
        reset_outputs_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_addr", imem_addr, RESET_PC);
        chk("first_req", imem_req, 1'b1);

        // Straight-line fetch, 1-cycle memory: first entry visible at cycle 2.
        tick(); tick();
        chk("lat_valid", fetch_valid, 1'b1);
        chk("lat_pcf", PCF, RESET_PC);
        repeat (16) tick();

        // Backpressure: hold the head, stop issuing once the buffer is full.
        StallF = 1'b1;
        repeat (5) begin
            tick();
            if (fetch_valid && exp_q.size() > 0)
                chk("stall_hold", PCF, exp_q[0]);
        end
        chk("stall_full_valid", fetch_valid, 1'b1);
        chk("stall_full_noreq", imem_req, 1'b0);
        chk("stall_buffered", exp_q.size(), 2);
        chk("stall_head", PCF, exp_q[0]);
        StallF = 1'b0;
        repeat (8) tick();

        // Memory not ready: request held, address stable.
        imem_ready = 1'b0;
        repeat (3) tick();
        #1;
        addr0 = imem_addr;
        chk("nready_addr_is_pc", addr0, model_pc);
        #1;
        repeat (4) begin
            chk("nready_req", imem_req, 1'b1);
            chk("nready_addr", imem_addr, addr0);
            tick();
        end
        imem_ready = 1'b1;
        repeat (8) tick();

        // Redirect with two responses in flight on a 3-cycle memory.
        lat = 3;
        for (int i = 0; i < 20; i++) begin
            if (mem_addr_q.size() >= 2) break;
            tick();
        end
        chk("inflight2", mem_addr_q.size(), 2);
        PCTargetE = 32'h100; PCSrcE = 1'b1;
        tick();
        PCSrcE = 1'b0;
        chk("redir_flushed", fetch_valid, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (fetch_valid) break;
            tick();
        end
        chk("redir_valid", fetch_valid, 1'b1);
        chk("redir_pcf", PCF, 32'h100);
        repeat (10) tick();

        // Redirect while stalled: buffer flushed, PC takes the target.
        lat = 1;
        StallF = 1'b1;
        repeat (6) tick();
        PCTargetE = 32'h200; PCSrcE = 1'b1;
        tick();
        PCSrcE = 1'b0;
        chk("stall_redir_valid", fetch_valid, 1'b0);
        chk("stall_redir_addr", imem_addr, 32'h200);
        StallF = 1'b0;
        repeat (10) tick();

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        reset_outputs_zero("async_rst");
        mem_addr_q.delete(); mem_due_q.delete(); exp_q.delete();
        model_pc = RESET_PC;
        imem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_addr", imem_addr, RESET_PC);
        chk("post_rst_req", imem_req, 1'b1);
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
